mac_frame_scheduler: RTL and testbench
======================================

# mac_frame_scheduler

Round-robin scheduler that shares one `mac_frame_generator` among `NUM_REQ` frame requesters. It arbitrates pending requests and drives the generator's start and length inputs plus a requester-select index for the external address/payload mux. It waits for the generator's done, then enforces a programmable inter-frame gap. A watchdog aborts a frame that never completes.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `PAYLOAD_MAX_SIZE`, 1500: largest legal payload length in bytes.
- `IFG_CYCLES`, 12: idle cycles after each frame; 0 is legal.
- `TIMEOUT_CYCLES`, 512: maximum cycles from start to done.

Ports:
- `clk` input 1: single clock; all logic rises on it.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_req` input NUM_REQ: level request per requester; held until its `o_ack` bit.
- `i_req_len` input NUM_REQ*16: payload length per requester, requester k at bits [16k+15:16k]; sampled at grant.
- `i_gen_done` input 1: generator frame-complete pulse.
- `o_ack` output NUM_REQ: one-cycle completion pulse to the granted requester.
- `o_err` output 1: one-cycle pulse alongside `o_ack` when the frame was rejected or timed out.
- `o_gen_start` output 1: one-cycle start pulse to the generator.
- `o_gen_payload_length` output 16: latched length of the granted request.
- `o_gen_sel` output $clog2(NUM_REQ): index of the granted requester.
- `o_gen_interrupt` output 8: driven to 8'hFF for one cycle on timeout abort, otherwise 8'h00.
- `o_busy` output 1: high in every state except IDLE.
- `o_frame_count` output 32: number of frames completed successfully; wraps.

## Operation
States: IDLE, START, WAIT_DONE, GAP.

IDLE:
- If `i_req` has any bit set, grant round-robin. Search starts at `rr_ptr`, which is (last grant + 1) mod NUM_REQ.
- Latch the grant index into `o_gen_sel` and its length into `o_gen_payload_length`.
- If the length > PAYLOAD_MAX_SIZE:
  - pulse `o_ack[grant]` and `o_err` on the next cycle;
  - do not start the generator;
  - go to GAP.
- Otherwise go to START.

START:
- `o_gen_start` = 1 for exactly this cycle.
- Clear the watchdog counter.
- Go to WAIT_DONE.

WAIT_DONE:
- Watchdog increments every cycle.
- On `i_gen_done`: pulse `o_ack[grant]` the next cycle, increment `o_frame_count`, go to GAP.
- If the watchdog reaches TIMEOUT_CYCLES first:
  - drive `o_gen_interrupt` = 8'hFF for one cycle;
  - pulse `o_ack[grant]` and `o_err`;
  - go to GAP;
  - do not increment `o_frame_count`.
- If `i_gen_done` arrives on the same cycle the watchdog expires, `i_gen_done` wins and the frame counts as success.

GAP:
- Counter loaded with IFG_CYCLES on entry; decrements to 0, then go to IDLE.
- If IFG_CYCLES = 0, GAP lasts zero cycles: the state moves straight to IDLE.
- `rr_ptr` updates at the grant edge, so the requester just served has lowest priority next time.

Other rules:
- `i_gen_done` outside WAIT_DONE is ignored.
- A requester that drops `i_req` before grant is simply skipped; after grant its request is committed.
- `i_req_len` changes after grant have no effect.

Reset (asynchronous, any state): state = IDLE, `rr_ptr` = 0, and every output = 0. That covers `o_gen_sel`, `o_gen_payload_length`, `o_frame_count` and `o_gen_interrupt`, which resets to 8'h00. An in-flight frame is abandoned without `o_ack`.

## Timing
- Request to start: `i_req` seen in IDLE at edge N gives `o_gen_start` high in cycle N+1.
- Select and length hold stable from cycle N+1 until the next grant.
- Done to ack: `i_gen_done` at edge M gives `o_ack` high in cycle M+1, and GAP begins at M+1.
- The next grant edge is the earliest edge at which IDLE samples `i_req` after the gap has expired.
- Watchdog: no done gives `o_err`, `o_ack` and the interrupt one cycle after the watchdog count reaches TIMEOUT_CYCLES, measured from START.
- Rejected length: `o_ack` and `o_err` are high in cycle N+1; `o_gen_start` never rises.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Single request: req[0]=1 with len=46, generator done 10 cycles after start.
  - Expect one `o_gen_start` pulse with sel=0 and length=46.
  - Expect `o_ack` = 4'b0001 one cycle after done, `o_frame_count` = 1, and `o_busy` low after 12 gap cycles.
- Round-robin fairness: all four requesters held high.
  - Grant order 0,1,2,3,0.
  - Each grant separated by at least IFG_CYCLES after the previous done; no requester granted twice in a row.
- Oversize reject: req[2]=1 with len=1501.
  - Expect `o_ack[2]` and `o_err` in the cycle after grant, no `o_gen_start`, and `o_frame_count` unchanged.
- Watchdog: start issued, done never asserted.
  - At start+512 expect `o_gen_interrupt` = 8'hFF for one cycle, with `o_ack` and `o_err` pulsing together.
  - Expect `o_frame_count` unchanged.
  - Repeat with done arriving on the expiry cycle: expect success and no `o_err`.
- IFG_CYCLES=0 build, back-to-back requests: next `o_gen_start` exactly 2 cycles after done (the cycle of `o_ack`, then IDLE).
- Reset mid-frame: assert `i_rst` during WAIT_DONE.
  - All outputs return to 0 immediately (asynchronous), with no `o_ack`.
  - After release the next grant goes to requester 0.

Source files
------------

// File: rtl/mac_frame_scheduler.sv
// Round-robin scheduler that shares one frame generator among NUM_REQ
// requesters. It grants a pending request, starts the generator, waits for
// done under a watchdog, then holds off for a programmable inter-frame gap.
module mac_frame_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int IFG_CYCLES       = 12,
    parameter int TIMEOUT_CYCLES   = 512
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ*16-1:0]      i_req_len,
    input  logic                       i_gen_done,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic                       o_err,
    output logic                       o_gen_start,
    output logic [15:0]                o_gen_payload_length,
    output logic [$clog2(NUM_REQ)-1:0] o_gen_sel,
    output logic [7:0]                 o_gen_interrupt,
    output logic                       o_busy,
    output logic [31:0]                o_frame_count
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [NUM_REQ-1:0] ACK_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;

    // With a zero gap a finished frame drops straight back to IDLE.
    localparam logic [1:0] POST_FRAME = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;

    logic [1:0]       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [15:0]      grant_len;

    // Index arithmetic modulo NUM_REQ, which need not be a power of two.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return SEL_W'(sum);
    endfunction

    // Round-robin pick: first requesting index at or after rr_ptr.
    always_comb begin
        // NOTE: defaults ahead of the loop keep every path assigned, so no latch is inferred.
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && i_req[wrap_add(rr_ptr, i)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_add(rr_ptr, i);
            end
        end
    end

    assign grant_len = i_req_len[{grant_idx, 4'b0000} +: 16];

    // Busy decodes a register only, so it carries no input-to-output path.
    assign o_busy = (state != S_IDLE);

    // Scheduler FSM, watchdog and gap timers, and all registered outputs.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state                <= S_IDLE;
            rr_ptr               <= '0;
            wd_cnt               <= '0;
            gap_cnt              <= '0;
            o_ack                <= '0;
            o_err                <= 1'b0;
            o_gen_start          <= 1'b0;
            o_gen_payload_length <= '0;
            o_gen_sel            <= '0;
            o_gen_interrupt      <= 8'h00;
            o_frame_count        <= '0;
        end else begin
            // NOTE: state uses non-blocking assignment so every branch sees pre-edge values;
            // the pulse outputs default low here and are raised only in their one cycle.
            o_ack           <= '0;
            o_err           <= 1'b0;
            o_gen_start     <= 1'b0;
            o_gen_interrupt <= 8'h00;

            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        o_gen_sel            <= grant_idx;
                        o_gen_payload_length <= grant_len;
                        rr_ptr               <= wrap_add(grant_idx, 1);
                        if (grant_len > 16'(PAYLOAD_MAX_SIZE)) begin
                            o_ack   <= ACK_ONE << grant_idx;
                            o_err   <= 1'b1;
                            gap_cnt <= GAP_W'(IFG_CYCLES);
                            state   <= POST_FRAME;
                        end else begin
                            o_gen_start <= 1'b1;
                            state       <= S_START;
                        end
                    end
                end

                S_START: begin
                    // The start cycle itself is the first cycle the watchdog counts.
                    wd_cnt <= WD_W'(1);
                    state  <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    // Done is tested first so it wins a tie with watchdog expiry.
                    if (i_gen_done) begin
                        o_ack         <= ACK_ONE << o_gen_sel;
                        o_frame_count <= o_frame_count + 32'd1;
                        gap_cnt       <= GAP_W'(IFG_CYCLES);
                        state         <= POST_FRAME;
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        o_ack           <= ACK_ONE << o_gen_sel;
                        o_err           <= 1'b1;
                        o_gen_interrupt <= 8'hFF;
                        gap_cnt         <= GAP_W'(IFG_CYCLES);
                        state           <= POST_FRAME;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_W'(1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_frame_scheduler.sv
// Self-checking bench for mac_frame_scheduler: a default build (gap 12) and a
// zero-gap build, driven with randomized requests and checked against a
// transaction-level round-robin model.
module tb_mac_frame_scheduler;

    localparam int NUM_REQ = 4;
    localparam int MAX_LEN = 1500;
    localparam int IFG     = 12;
    localparam int TIMEOUT = 512;

    logic        clk = 1'b0;
    logic        i_rst;

    logic [3:0]  i_req;
    logic [63:0] i_req_len;
    logic        i_gen_done;
    logic [3:0]  o_ack;
    logic        o_err;
    logic        o_gen_start;
    logic [15:0] o_gen_payload_length;
    logic [1:0]  o_gen_sel;
    logic [7:0]  o_gen_interrupt;
    logic        o_busy;
    logic [31:0] o_frame_count;

    logic [3:0]  z_req;
    logic [63:0] z_req_len;
    logic        z_done;
    logic [3:0]  z_ack;
    logic        z_err;
    logic        z_start;
    logic [15:0] z_len;
    logic [1:0]  z_sel;
    logic [7:0]  z_irq;
    logic        z_busy;
    logic [31:0] z_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: next round-robin start point and success count.
    int model_ptr   = 0;
    int model_count = 0;

    always #5 clk = ~clk;

    mac_frame_scheduler #(
        .NUM_REQ(NUM_REQ), .PAYLOAD_MAX_SIZE(MAX_LEN),
        .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_len(i_req_len),
        .i_gen_done(i_gen_done), .o_ack(o_ack), .o_err(o_err),
        .o_gen_start(o_gen_start), .o_gen_payload_length(o_gen_payload_length),
        .o_gen_sel(o_gen_sel), .o_gen_interrupt(o_gen_interrupt),
        .o_busy(o_busy), .o_frame_count(o_frame_count)
    );

    mac_frame_scheduler #(
        .NUM_REQ(NUM_REQ), .PAYLOAD_MAX_SIZE(MAX_LEN),
        .IFG_CYCLES(0), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut_zero_gap (
        .clk(clk), .i_rst(i_rst), .i_req(z_req), .i_req_len(z_req_len),
        .i_gen_done(z_done), .o_ack(z_ack), .o_err(z_err),
        .o_gen_start(z_start), .o_gen_payload_length(z_len),
        .o_gen_sel(z_sel), .o_gen_interrupt(z_irq),
        .o_busy(z_busy), .o_frame_count(z_count)
    );

    // First requesting index at or after ptr, modulo NUM_REQ.
    function automatic int model_pick(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [15:0] rand_len(input bit allow_over);
        if (allow_over && $urandom_range(0, 3) == 0) return 16'($urandom_range(MAX_LEN + 1, 9000));
        return 16'($urandom_range(0, MAX_LEN));
    endfunction

    task automatic apply_reset();
        i_rst      = 1'b1;
        i_req      = '0;
        z_req      = '0;
        i_gen_done = 1'b0;
        z_done     = 1'b0;
        repeat (2) @(negedge clk);
        i_rst       = 1'b0;
        model_ptr   = 0;
        model_count = 0;
    endtask

    task automatic wait_start(input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (o_gen_start) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output int n, output bit ok, output bit saw_start);
        n         = 0;
        ok        = 1'b0;
        saw_start = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (o_gen_start) saw_start = 1'b1;
            if (!o_busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({o_ack, o_err, o_gen_start, o_gen_interrupt, o_busy} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h expected 0", {o_ack, o_err, o_gen_start, o_gen_interrupt, o_busy});
        end
        n_checks++;
        if (o_gen_payload_length !== 16'd0 || o_gen_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_sel_len: got sel=%0d len=%0d expected 0/0", o_gen_sel, o_gen_payload_length);
        end
        n_checks++;
        if (o_frame_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", o_frame_count);
        end
        i_rst       = 1'b0;
        model_ptr   = 0;
        model_count = 0;
    endtask

    task automatic test_single();
        int n, g;
        bit ok, saw, early;
        i_req     = 4'b0001;
        i_req_len = '0;
        i_req_len[15:0] = 16'd46;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        wait_start(4, n, ok);
        n_checks++;
        if (!ok || n != 1) begin
            n_fail++;
            $display("FAIL single_latency: got ok=%0d cycles=%0d expected 1", ok, n);
        end
        n_checks++;
        if (o_gen_sel !== 2'(g) || o_gen_payload_length !== 16'd46) begin
            n_fail++;
            $display("FAIL single_sel_len: got sel=%0d len=%0d expected %0d/46", o_gen_sel, o_gen_payload_length, g);
        end
        early = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_ack !== 4'd0 || o_err !== 1'b0 || o_gen_start !== 1'b0) early = 1'b1;
        end
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        model_count++;
        n_checks++;
        if (early || o_ack !== 4'b0001 || o_err !== 1'b0 || o_frame_count !== 32'(model_count)) begin
            n_fail++;
            $display("FAIL single_ack: got early=%0d ack=%b err=%0d count=%0d expected 0/0001/0/%0d",
                     early, o_ack, o_err, o_frame_count, model_count);
        end
        i_req = '0;
        @(negedge clk);
        n_checks++;
        if (o_ack !== 4'd0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack_width: got ack=%b busy=%0d expected 0000/1", o_ack, o_busy);
        end
        wait_idle(IFG + 8, n, ok, saw);
        n_checks++;
        if (!ok || saw || n + 1 != IFG) begin
            n_fail++;
            $display("FAIL single_gap: got ok=%0d start=%0d gap=%0d expected gap %0d", ok, saw, n + 1, IFG);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] lens [4];
        int n, g, d, prev;
        bit ok;
        apply_reset();
        for (int k = 0; k < NUM_REQ; k++) lens[k] = rand_len(1'b0);
        i_req_len = {lens[3], lens[2], lens[1], lens[0]};
        i_req     = 4'hF;
        prev      = -1;
        for (int f = 0; f < 5; f++) begin
            g = model_pick(i_req, model_ptr);
            model_ptr = (g + 1) % NUM_REQ;
            wait_start(IFG + 10, n, ok);
            n_checks++;
            if (!ok || n != ((f == 0) ? 1 : IFG + 1)) begin
                n_fail++;
                $display("FAIL rr_spacing: got ok=%0d cycles=%0d expected %0d", ok, n, (f == 0) ? 1 : IFG + 1);
            end
            n_checks++;
            if (o_gen_sel !== 2'(g) || int'(o_gen_sel) == prev || o_gen_payload_length !== lens[g]) begin
                n_fail++;
                $display("FAIL rr_order: got sel=%0d len=%0d expected sel=%0d len=%0d (prev %0d)",
                         o_gen_sel, o_gen_payload_length, g, lens[g], prev);
            end
            prev = g;
            d = $urandom_range(1, 20);
            repeat (d) @(negedge clk);
            i_gen_done = 1'b1;
            @(negedge clk);
            i_gen_done = 1'b0;
            model_count++;
            n_checks++;
            if (o_ack !== 4'(1 << g) || o_frame_count !== 32'(model_count)) begin
                n_fail++;
                $display("FAIL rr_ack: got ack=%b count=%0d expected %b/%0d", o_ack, o_frame_count, 4'(1 << g), model_count);
            end
        end
        i_req = '0;
        wait_idle(IFG + 8, n, ok, prev[0]);
    endtask

    task automatic test_oversize();
        int n, g, d;
        bit ok, saw;
        i_req_len = {rand_len(1'b0), 16'd1501, rand_len(1'b0), rand_len(1'b0)};
        i_req     = 4'b0100;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        n_checks++;
        if (o_ack !== 4'b0100 || o_err !== 1'b1 || o_gen_start !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize_ack: got ack=%b err=%0d start=%0d expected 0100/1/0", o_ack, o_err, o_gen_start);
        end
        n_checks++;
        if (o_frame_count !== 32'(model_count) || o_gen_sel !== 2'(g) || o_gen_payload_length !== 16'd1501) begin
            n_fail++;
            $display("FAIL oversize_state: got count=%0d sel=%0d len=%0d expected %0d/%0d/1501",
                     o_frame_count, o_gen_sel, o_gen_payload_length, model_count, g);
        end
        i_req = '0;
        wait_idle(IFG + 8, n, ok, saw);
        n_checks++;
        if (!ok || saw || n != IFG) begin
            n_fail++;
            $display("FAIL oversize_gap: got ok=%0d start=%0d gap=%0d expected gap %0d", ok, saw, n, IFG);
        end
        // Exactly the maximum length is legal.
        i_req_len[47:32] = 16'(MAX_LEN);
        i_req = 4'b0100;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        @(negedge clk);
        n_checks++;
        if (o_gen_start !== 1'b1 || o_err !== 1'b0 || o_ack !== 4'd0) begin
            n_fail++;
            $display("FAIL maxlen_accept: got start=%0d err=%0d ack=%b expected 1/0/0000", o_gen_start, o_err, o_ack);
        end
        d = $urandom_range(1, 10);
        repeat (d) @(negedge clk);
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        i_req = '0;
        model_count++;
        n_checks++;
        if (o_ack !== 4'b0100 || o_frame_count !== 32'(model_count)) begin
            n_fail++;
            $display("FAIL maxlen_done: got ack=%b count=%0d expected 0100/%0d", o_ack, o_frame_count, model_count);
        end
        wait_idle(IFG + 8, n, ok, saw);
    endtask

    task automatic test_watchdog();
        int n, g;
        bit ok, saw, early;
        i_req_len = {rand_len(1'b0), rand_len(1'b0), 16'd100, rand_len(1'b0)};
        i_req = 4'b0010;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        wait_start(4, n, ok);
        // Count cycles from the start pulse to the first ack or interrupt.
        n = 0;
        ok = 1'b0;
        while (n < TIMEOUT + 50 && !ok) begin
            @(negedge clk);
            n++;
            if (o_ack !== 4'd0 || o_gen_interrupt !== 8'h00) ok = 1'b1;
        end
        n_checks++;
        if (!ok || n != TIMEOUT) begin
            n_fail++;
            $display("FAIL wd_latency: got ok=%0d cycles=%0d expected %0d", ok, n, TIMEOUT);
        end
        n_checks++;
        if (o_gen_interrupt !== 8'hFF || o_ack !== 4'(1 << g) || o_err !== 1'b1 ||
            o_frame_count !== 32'(model_count)) begin
            n_fail++;
            $display("FAIL wd_abort: got irq=%h ack=%b err=%0d count=%0d expected ff/%b/1/%0d",
                     o_gen_interrupt, o_ack, o_err, o_frame_count, 4'(1 << g), model_count);
        end
        i_req = '0;
        @(negedge clk);
        n_checks++;
        if (o_gen_interrupt !== 8'h00 || o_err !== 1'b0 || o_ack !== 4'd0) begin
            n_fail++;
            $display("FAIL wd_pulse_width: got irq=%h err=%0d ack=%b expected 00/0/0000", o_gen_interrupt, o_err, o_ack);
        end
        wait_idle(IFG + 8, n, ok, saw);
        // Done arriving on the expiry cycle wins.
        i_req = 4'b0010;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        wait_start(4, n, ok);
        early = 1'b0;
        repeat (TIMEOUT - 1) begin
            @(negedge clk);
            if (o_ack !== 4'd0 || o_gen_interrupt !== 8'h00) early = 1'b1;
        end
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        i_req = '0;
        model_count++;
        n_checks++;
        if (early || o_ack !== 4'(1 << g) || o_err !== 1'b0 || o_gen_interrupt !== 8'h00 ||
            o_frame_count !== 32'(model_count)) begin
            n_fail++;
            $display("FAIL wd_race: got early=%0d ack=%b err=%0d irq=%h count=%0d expected 0/%b/0/00/%0d",
                     early, o_ack, o_err, o_gen_interrupt, o_frame_count, 4'(1 << g), model_count);
        end
        wait_idle(IFG + 8, n, ok, saw);
    endtask

    task automatic test_random();
        logic [15:0] lens [4];
        logic [15:0] exp_len;
        logic [3:0]  mask;
        int n, g, d, stray;
        bit ok, saw, over, early;
        for (int f = 0; f < 14; f++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < NUM_REQ; k++) lens[k] = rand_len(1'b1);
            i_req_len = {lens[3], lens[2], lens[1], lens[0]};
            i_req     = mask;
            g = model_pick(mask, model_ptr);
            model_ptr = (g + 1) % NUM_REQ;
            exp_len = lens[g];
            over = (exp_len > 16'(MAX_LEN));
            @(negedge clk);
            n_checks++;
            if (o_gen_sel !== 2'(g) || o_gen_payload_length !== exp_len || o_gen_start !== !over ||
                o_err !== over || o_ack !== (over ? 4'(1 << g) : 4'd0)) begin
                n_fail++;
                $display("FAIL rand_grant: got sel=%0d len=%0d start=%0d err=%0d ack=%b expected %0d/%0d/%0d/%0d (mask %b)",
                         o_gen_sel, o_gen_payload_length, o_gen_start, o_err, o_ack, g, exp_len, !over, over, mask);
            end
            // Lengths changing after the grant must not disturb the latched value.
            i_req_len = {rand_len(1'b1), rand_len(1'b1), rand_len(1'b1), rand_len(1'b1)};
            if (!over) begin
                i_req = 4'(1 << g);
                early = 1'b0;
                d = $urandom_range(1, 40);
                repeat (d) begin
                    @(negedge clk);
                    if (o_ack !== 4'd0 || o_gen_interrupt !== 8'h00) early = 1'b1;
                end
                i_gen_done = 1'b1;
                @(negedge clk);
                i_gen_done = 1'b0;
                model_count++;
                n_checks++;
                if (early || o_ack !== 4'(1 << g) || o_err !== 1'b0 ||
                    o_frame_count !== 32'(model_count) || o_gen_payload_length !== exp_len) begin
                    n_fail++;
                    $display("FAIL rand_done: got early=%0d ack=%b err=%0d count=%0d len=%0d expected 0/%b/0/%0d/%0d",
                             early, o_ack, o_err, o_frame_count, o_gen_payload_length, 4'(1 << g), model_count, exp_len);
                end
            end
            i_req = '0;
            stray = 0;
            if ($urandom_range(0, 1) == 1) begin
                // A done pulse during the gap must be ignored.
                i_gen_done = 1'b1;
                @(negedge clk);
                i_gen_done = 1'b0;
                stray = 1;
            end
            wait_idle(IFG + 8, n, ok, saw);
            n_checks++;
            if (!ok || saw || n + stray != IFG || o_frame_count !== 32'(model_count)) begin
                n_fail++;
                $display("FAIL rand_gap: got ok=%0d start=%0d gap=%0d count=%0d expected gap %0d count %0d",
                         ok, saw, n + stray, o_frame_count, IFG, model_count);
            end
        end
    endtask

    task automatic test_ifg_zero();
        int n, g, d, zptr, zcount;
        bit ok;
        apply_reset();
        zptr   = 0;
        zcount = 0;
        z_req_len = {rand_len(1'b0), 16'd64, rand_len(1'b0), 16'd64};
        z_req     = 4'b0101;
        n  = 0;
        ok = 1'b0;
        while (n < 4 && !ok) begin
            @(negedge clk);
            n++;
            if (z_start) ok = 1'b1;
        end
        n_checks++;
        if (!ok || n != 1) begin
            n_fail++;
            $display("FAIL z_first_start: got ok=%0d cycles=%0d expected 1", ok, n);
        end
        for (int f = 0; f < 4; f++) begin
            g = model_pick(z_req, zptr);
            zptr = (g + 1) % NUM_REQ;
            n_checks++;
            if (z_sel !== 2'(g)) begin
                n_fail++;
                $display("FAIL z_sel: got %0d expected %0d", z_sel, g);
            end
            d = $urandom_range(1, 8);
            repeat (d) @(negedge clk);
            z_done = 1'b1;
            @(negedge clk);
            z_done = 1'b0;
            zcount++;
            n_checks++;
            if (z_ack !== 4'(1 << g) || z_count !== 32'(zcount) || z_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL z_ack: got ack=%b count=%0d busy=%0d expected %b/%0d/0", z_ack, z_count, z_busy, 4'(1 << g), zcount);
            end
            if (f == 3) begin
                z_req = '0;
            end else begin
                n  = 0;
                ok = 1'b0;
                while (n < 6 && !ok) begin
                    @(negedge clk);
                    n++;
                    if (z_start) ok = 1'b1;
                end
                n_checks++;
                if (!ok || n != 1) begin
                    n_fail++;
                    $display("FAIL z_back_to_back: got ok=%0d cycles after ack=%0d expected 1", ok, n);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int n, g;
        bit ok, saw, acked;
        apply_reset();
        i_req_len = {rand_len(1'b0), 16'd60, rand_len(1'b0), rand_len(1'b0)};
        i_req = 4'b0100;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        wait_start(4, n, ok);
        repeat (3) @(negedge clk);
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        i_req = '0;
        model_count++;
        wait_idle(IFG + 8, n, ok, saw);
        i_req_len[31:16] = 16'd80;
        i_req = 4'b0010;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        wait_start(4, n, ok);
        repeat (4) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1 || o_frame_count !== 32'(model_count) || o_gen_sel !== 2'(g)) begin
            n_fail++;
            $display("FAIL midframe_setup: got busy=%0d count=%0d sel=%0d expected 1/%0d/%0d", o_busy, o_frame_count, o_gen_sel, model_count, g);
        end
        i_rst = 1'b1;
        #1;
        n_checks++;
        if ({o_ack, o_err, o_gen_start, o_gen_interrupt, o_busy} !== 15'd0 || o_frame_count !== 32'd0 ||
            o_gen_sel !== 2'd0 || o_gen_payload_length !== 16'd0) begin
            n_fail++;
            $display("FAIL midframe_async_reset: got ctrl=%h count=%0d sel=%0d len=%0d expected all 0",
                     {o_ack, o_err, o_gen_start, o_gen_interrupt, o_busy}, o_frame_count, o_gen_sel, o_gen_payload_length);
        end
        acked = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_ack !== 4'd0) acked = 1'b1;
        end
        i_req = 4'hF;
        i_rst = 1'b0;
        model_ptr   = 0;
        model_count = 0;
        g = model_pick(i_req, model_ptr);
        model_ptr = (g + 1) % NUM_REQ;
        wait_start(4, n, ok);
        n_checks++;
        if (acked || !ok || o_gen_sel !== 2'(g)) begin
            n_fail++;
            $display("FAIL post_reset_grant: got acked=%0d ok=%0d sel=%0d expected 0/1/%0d", acked, ok, o_gen_sel, g);
        end
        i_req = 4'(1 << g);
        repeat (2) @(negedge clk);
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        i_req = '0;
        wait_idle(IFG + 8, n, ok, saw);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_req      = '0;
        i_req_len  = '0;
        i_gen_done = 1'b0;
        z_req      = '0;
        z_req_len  = '0;
        z_done     = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_oversize();
        test_watchdog();
        test_random();
        test_ifg_zero();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish within 300000 time units");
        $fatal(1, "bench time limit expired");
    end

endmodule
